fir_sample_pacer: RTL and testbench
===================================

Name: fir_sample_pacer

Overview:
Input pacing stage placed directly upstream of the decimating polyphase FIR. It accepts a bursty ready/valid sample stream and buffers it in a small FIFO. It re-emits samples as single-cycle strobes with a guaranteed minimum spacing, so the FIR's compute FSM always returns to idle before the next sample arrives and never raises its "dval too fast" error. Sticky overflow and level outputs go to the control/status registers.

Parameters:
DATA_WIDTH, 16, sample width (signed, passed through unchanged)
DEPTH, 16, FIFO depth in samples; must be a power of 2, >= 2
MIN_GAP, 12, minimum clock cycles between consecutive data_val_o pulses; must be >= 2; set to FILTER_ORDER/DECIMATION + 4 for the downstream FIR
AWIDTH, $clog2(DEPTH), FIFO pointer width (derived, do not override)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_i  in  DATA_WIDTH  input sample
data_val_i  in  1  input sample valid
data_rdy_o  out  1  space available; a sample is accepted when data_val_i && data_rdy_o
flush_i  in  1  synchronous FIFO clear
clr_err_i  in  1  clears overflow_o
data_o  out  DATA_WIDTH  paced sample; held stable between pulses
data_val_o  out  1  single-cycle strobe marking a new data_o
level_o  out  AWIDTH+1  current FIFO occupancy, 0..DEPTH
overflow_o  out  1  sticky: a sample was offered while full

Behaviour:
- Reset values (async, immediate): data_o=0, data_val_o=0, level_o=0, overflow_o=0, data_rdy_o=1, pointers=0, FSM=IDLE, gap counter=0.
- data_rdy_o = (count < DEPTH). It is derived from registered count only, with no combinational path from data_val_i.
- Write: when data_val_i && data_rdy_o, store data_i at wr_ptr, advance wr_ptr modulo DEPTH, increment count.
- Read: on the edge that enters ISSUE, load data_o from fifo[rd_ptr], advance rd_ptr modulo DEPTH, decrement count.
- A write and a read on the same edge leave count unchanged.
- Pointer wrap is natural modulo 2^AWIDTH.
- FSM:
  - IDLE: if count>0, go to ISSUE (performs the read).
  - ISSUE: data_val_o=1 for exactly this cycle; gap counter loaded with MIN_GAP-2; go to HOLDOFF.
  - HOLDOFF: decrement gap counter. At 0: if count>0, go directly to ISSUE (performs the read); else go to IDLE.
- Pulse spacing is exactly MIN_GAP cycles under backlog and >= MIN_GAP always.
- Latency: sample presented in cycle C into an empty FIFO with FSM in IDLE gives data_val_o high in cycle C+2, with data_o equal to that sample.
- Overflow: data_val_i with count==DEPTH drops the sample and sets overflow_o on the next edge. overflow_o stays set until clr_err_i.
- Overflow set and clr_err_i on the same edge: set wins.
- Flush:
  - Resets pointers and count to 0 on the next edge. Does not alter data_o, the FSM or the gap counter.
  - A pulse already in ISSUE completes, and the hold-off still elapses.
  - A write on the flush cycle is discarded and does not set overflow.
  - A read scheduled on the flush edge is suppressed: FSM goes to IDLE, not ISSUE.
- data_val_o never asserts for a sample not previously accepted.
- No sample is ever duplicated or reordered.
- Reset mid-burst returns all state to reset values immediately. The first accepted sample after reset follows the C+2 latency rule.

Decomposition:
- Package fir_pkg holds:
  - the state enum pacer_state_t {IDLE_S, ISSUE_S, HOLDOFF_S}
  - the error bit constant ERR_OVERFLOW = 2'h1, aligned with the FIR err_flg_o encoding so the status register can OR them
- Natural sub-module: fifo_sync_reg, a register-based synchronous FIFO with count, full and empty outputs, parameterised by DATA_WIDTH/DEPTH and with a flush input. The pacing FSM and gap counter stay in fir_sample_pacer.

Test Plan:
- Single sample 0x1234 at cycle 10, MIN_GAP=12 -> data_val_o high only in cycle 12; data_o=0x1234 and held; level_o returns to 0.
- Burst of 4 back-to-back samples 1,2,3,4 from cycle 10 -> pulses at cycles 12, 24, 36, 48 carrying 1..4 in order; level_o peaks at 3.
- DEPTH=16, 20 back-to-back samples from cycle 0 -> data_rdy_o low once 16 are held; further data_val_i sets overflow_o; exactly the accepted samples emerge in order; clr_err_i clears overflow_o.
- 40 samples paced every 12 cycles -> pointers wrap twice; outputs match inputs 1:1 with no gaps above 12 cycles.
- 5 samples buffered, flush_i asserted in cycle 1 of hold-off -> level_o=0 next cycle; no further pulses; a new sample after flush emerges no earlier than 12 cycles after the last pulse.
- rst_i asserted asynchronously mid-hold-off with 3 samples queued -> all outputs zero immediately, data_rdy_o=1; no pulse after release until new input, which emerges at C+2.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR input pacing stage.
package fir_pkg;

    // Pacing FSM states.
    typedef enum logic [1:0] {
        IDLE_S    = 2'd0,
        ISSUE_S   = 2'd1,
        HOLDOFF_S = 2'd2
    } pacer_state_t;

    // Overflow bit position, aligned with the FIR err_flg_o encoding so the
    // status register can OR the two error vectors together.
    localparam logic [1:0] ERR_OVERFLOW = 2'h1;

endpackage

// File: rtl/fifo_sync_reg.sv
// Register-based synchronous FIFO with occupancy count and a synchronous flush.
// Flush clears pointers and count and overrides any write or read on that edge.
module fifo_sync_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AWIDTH     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [AWIDTH:0]       count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]       count_q, count_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign wr_fire = wr_en_i && !full_o && !flush_i;
    assign rd_fire = rd_en_i && !empty_o && !flush_i;

    // Next-state for pointers and count; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are only meaningful where count marks them valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fir_sample_pacer.sv
// Input pacer for the decimating FIR: buffers a bursty ready/valid stream and
// re-emits samples as single-cycle strobes spaced at least MIN_GAP cycles apart.
//
// Handshake: a sample is accepted on any edge where data_val_i && data_rdy_o;
// data_rdy_o comes from the registered FIFO count only, so it never depends on
// data_val_i in the same cycle. Output side has no back-pressure: data_val_o
// is a one-cycle strobe and data_o holds until the next strobe.
module fir_sample_pacer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int MIN_GAP    = 12,
    parameter int AWIDTH     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_val_i,
    output logic                  data_rdy_o,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_val_o,
    output logic [AWIDTH:0]       level_o,
    output logic                  overflow_o
);

    // Gap counter counts down MIN_GAP-2 .. 0 in HOLDOFF; ISSUE and the final
    // HOLDOFF cycle make up the remaining two cycles of the spacing.
    localparam int              GW       = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(MIN_GAP - 2);

    pacer_state_t          state_q, state_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  overflow_q;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [AWIDTH:0]       fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    fifo_sync_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AWIDTH     (AWIDTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .wr_en_i    (data_val_i),
        .wr_data_i  (data_i),
        .rd_en_i    (rd_req),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Pacing FSM next-state; a read is requested exactly on edges entering ISSUE,
    // and a flush in the same cycle suppresses it (FSM falls back to IDLE).
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rd_req  = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (!fifo_empty && !flush_i) begin
                    state_d = ISSUE_S;
                    rd_req  = 1'b1;
                end
            end
            ISSUE_S: begin
                state_d = HOLDOFF_S;
                gap_d   = GAP_LOAD;
            end
            HOLDOFF_S: begin
                if (gap_q == '0) begin
                    if (!fifo_empty && !flush_i) begin
                        state_d = ISSUE_S;
                        rd_req  = 1'b1;
                    end else begin
                        state_d = IDLE_S;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    // FSM state and gap counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE_S;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Output sample register, loaded on the edge that enters ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (rd_req) begin
            data_q <= fifo_rd_data;
        end
    end

    // Sticky overflow: a sample offered while full (outside a flush) sets it,
    // and setting wins over a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (data_val_i && fifo_full && !flush_i) begin
            overflow_q <= 1'b1;
        end else if (clr_err_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign data_rdy_o = !fifo_full;
    assign data_o     = data_q;
    assign data_val_o = (state_q == ISSUE_S);
    assign level_o    = fifo_count;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed bench for fir_sample_pacer (DATA_WIDTH=16, DEPTH=16, MIN_GAP=12).
module tb_fir_sample_pacer;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int MG = 12;
    localparam int AW = $clog2(DP);

    // Clock / reset
    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] data_i;
    logic          data_val_i;
    logic          data_rdy_o;
    logic          flush_i;
    logic          clr_err_i;
    logic [DW-1:0] data_o;
    logic          data_val_o;
    logic [AW:0]   level_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fir_sample_pacer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .MIN_GAP    (MG)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .data_val_i (data_val_i),
        .data_rdy_o (data_rdy_o),
        .flush_i    (flush_i),
        .clr_err_i  (clr_err_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    // Scoreboard
    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc[$];
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    int            peak = 0;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_i && data_val_o) begin
            got_q.push_back(data_o);
            got_cyc.push_back(cyc);
        end
        if (32'(level_o) > peak) peak = 32'(level_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        data_i     = v;
        data_val_i = 1'b1;
        tick();
        data_val_i = 1'b0;
    endtask

    task automatic push_exp(input logic [DW-1:0] v, input int c);
        exp_q.push_back(v);
        exp_cyc.push_back(c);
    endtask

    task automatic check_pulses(input string tag);
        chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            chk($sformatf("%s_cyc%0d", tag, i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
        end
        exp_q.delete();
        exp_cyc.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    int c0;

    initial begin
        rst_i      = 1'b1;
        data_i     = '0;
        data_val_i = 1'b0;
        flush_i    = 1'b0;
        clr_err_i  = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_val", 32'(data_val_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'h0);
        chk("rst_rdy", 32'(data_rdy_o), 32'h1);
        rst_i = 1'b0;
        repeat (3) tick();
        got_q.delete();
        got_cyc.delete();

        // Single sample: strobe two cycles after acceptance, data held afterwards
        c0 = cyc;
        send(16'h1234);
        chk("single_level", 32'(level_o), 32'h1);
        repeat (15) tick();
        push_exp(16'h1234, c0 + 2);
        check_pulses("single");
        chk("single_hold", 32'(data_o), 32'h1234);
        chk("single_level_end", 32'(level_o), 32'h0);

        // Burst 1..4: pulses every MIN_GAP, peak occupancy 3
        peak = 0;
        c0 = cyc;
        for (int i = 1; i <= 4; i++) send(DW'(i));
        repeat (50) tick();
        for (int i = 0; i < 4; i++) push_exp(DW'(i + 1), c0 + 2 + MG * i);
        check_pulses("burst");
        chk("burst_peak", 32'(peak), 32'd3);

        // 20 back-to-back: 18 accepted (two reads drain during the burst), last 2 dropped
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            data_i     = DW'(100 + i);
            data_val_i = 1'b1;
            if (i == 17) chk("ovf_rdy_before_full", 32'(data_rdy_o), 32'h1);
            if (i == 18) begin
                chk("ovf_rdy_full", 32'(data_rdy_o), 32'h0);
                chk("ovf_level_full", 32'(level_o), 32'd16);
                chk("ovf_not_yet", 32'(overflow_o), 32'h0);
            end
            tick();
        end
        data_val_i = 1'b0;
        chk("ovf_set", 32'(overflow_o), 32'h1);
        repeat (230) tick();
        for (int i = 0; i < 18; i++) push_exp(DW'(100 + i), c0 + 2 + MG * i);
        check_pulses("ovf");
        chk("ovf_sticky", 32'(overflow_o), 32'h1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("ovf_cleared", 32'(overflow_o), 32'h0);
        chk("ovf_level_end", 32'(level_o), 32'h0);

        // 40 samples paced at MIN_GAP: pointers wrap, output 1:1 with exact spacing
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            send(DW'(16'h0A00 + i));
            repeat (MG - 1) tick();
        end
        repeat (10) tick();
        for (int i = 0; i < 40; i++) push_exp(DW'(16'h0A00 + i), c0 + 2 + MG * i);
        check_pulses("wrap");

        // Flush during hold-off of the second pulse; write on the flush cycle is dropped
        c0 = cyc;
        for (int i = 1; i <= 5; i++) send(DW'(16'h0F00 + i));
        repeat (10) tick();
        chk("flush_level_before", 32'(level_o), 32'd3);
        flush_i    = 1'b1;
        data_i     = 16'hDEAD;
        data_val_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        data_val_i = 1'b0;
        chk("flush_level", 32'(level_o), 32'h0);
        chk("flush_no_ovf", 32'(overflow_o), 32'h0);
        send(16'h5A5A);
        repeat (30) tick();
        push_exp(16'h0F01, c0 + 2);
        push_exp(16'h0F02, c0 + 14);
        push_exp(16'h5A5A, c0 + 26);
        check_pulses("flush");

        // Async reset mid-hold-off with 3 queued samples
        c0 = cyc;
        for (int i = 1; i <= 4; i++) send(DW'(16'h0070 + i));
        tick();
        chk("arst_level_before", 32'(level_o), 32'd3);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_data", 32'(data_o), 32'h0);
        chk("arst_val", 32'(data_val_o), 32'h0);
        chk("arst_level", 32'(level_o), 32'h0);
        chk("arst_ovf", 32'(overflow_o), 32'h0);
        chk("arst_rdy", 32'(data_rdy_o), 32'h1);
        got_q.delete();
        got_cyc.delete();
        tick();
        tick();
        rst_i = 1'b0;
        repeat (20) tick();
        chk("arst_no_pulse", 32'(got_q.size()), 32'h0);
        c0 = cyc;
        send(16'hBEEF);
        repeat (5) tick();
        push_exp(16'hBEEF, c0 + 2);
        check_pulses("arst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
